regfile_write_scheduler: RTL and testbench

Write-port scheduler for the 16x32 register file in the ARM pipeline. It shares the file's single write port between the pipeline write-back stage and a multi-cycle external unit (load/multiply coprocessor). Late results are buffered in a small FIFO, and a busy-register scoreboard flags read hazards to the decode stage. It sits between WB/the external unit and the register file's `writeBackEn`/`dest_wb`/`result_wb` inputs.

---
 rtl/regfile_write_scheduler_if.sv | 40 ++++
 rtl/regfile_write_scheduler.sv | 148 ++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of all non-clock signals between the scheduler, the pipeline (WB/decode),
// the external long-latency unit and the register file write port.
interface regfile_write_scheduler_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
);
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_dest;
    logic              ext_valid;
    logic [ADDR_W-1:0] ext_dest;
    logic [DATA_W-1:0] ext_data;
    logic              ext_ready;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic              src1_en;
    logic              src2_en;
    logic              hazard;
    logic              stall_req;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0] rf_data;
    logic [NREGS-1:0]  busy;
    logic              waw_err;

    modport master (
        output wb_en, wb_dest, wb_data, issue_en, issue_dest,
               ext_valid, ext_dest, ext_data, src1, src2, src1_en, src2_en,
        input  ext_ready, hazard, stall_req, rf_we, rf_dest, rf_data, busy, waw_err
    );

    modport slave (
        input  wb_en, wb_dest, wb_data, issue_en, issue_dest,
               ext_valid, ext_dest, ext_data, src1, src2, src1_en, src2_en,
        output ext_ready, hazard, stall_req, rf_we, rf_dest, rf_data, busy, waw_err
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Shares the register file write port between pipeline write-back and a buffered
// external result stream; tracks pending destinations and starvation of the buffer.
module regfile_write_scheduler #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int NREGS        = 16,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_scheduler_if.slave bus
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] fifo_dest_q [QDEPTH];
    logic [ADDR_W-1:0] fifo_dest_d [QDEPTH];
    logic [DATA_W-1:0] fifo_data_q [QDEPTH];
    logic [DATA_W-1:0] fifo_data_d [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic              stall_req_q, stall_req_d;
    logic              waw_err_q, waw_err_d;

    logic              fifo_empty, ext_ready, push, pop;
    logic              fwd1, fwd2, stale_entry;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic [PTR_W-1:0]  slot;

    // Write-back always wins the port; the buffer only drains in idle WB cycles.
    assign fifo_empty = (count_q == '0);
    assign ext_ready  = (count_q < CNT_W'(QDEPTH));
    assign push       = bus.ext_valid && ext_ready;
    assign pop        = !bus.wb_en && !fifo_empty;
    assign head_dest  = fifo_dest_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // The file writes on negedge, so a register being popped now is already readable.
    assign fwd1 = pop && (head_dest == bus.src1);
    assign fwd2 = pop && (head_dest == bus.src2);

    always_comb begin
        bus.rf_we   = 1'b0;
        bus.rf_dest = '0;
        bus.rf_data = '0;
        if (bus.wb_en) begin
            bus.rf_we   = 1'b1;
            bus.rf_dest = bus.wb_dest;
            bus.rf_data = bus.wb_data;
        end else if (!fifo_empty) begin
            bus.rf_we   = 1'b1;
            bus.rf_dest = head_dest;
            bus.rf_data = head_data;
        end
    end

    always_comb begin
        stale_entry = 1'b0;
        slot        = rd_ptr_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && !busy_q[fifo_dest_q[slot]]) begin
                stale_entry = 1'b1;
            end
            slot = slot + PTR_W'(1);
        end
    end

    always_comb begin
        fifo_dest_d = fifo_dest_q;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        busy_d      = busy_q;
        age_d       = age_q;

        if (push) begin
            fifo_dest_d[wr_ptr_q] = bus.ext_dest;
            fifo_data_d[wr_ptr_q] = bus.ext_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set is applied after clear so a same-cycle reissue keeps the register busy.
        if (pop) begin
            busy_d[head_dest] = 1'b0;
        end
        if (bus.issue_en) begin
            busy_d[bus.issue_dest] = 1'b1;
        end

        if (fifo_empty || pop) begin
            age_d = '0;
        end else if (age_q < AGE_W'(STARVE_LIMIT)) begin
            age_d = age_q + AGE_W'(1);
        end
        stall_req_d = (age_d >= AGE_W'(STARVE_LIMIT));

        waw_err_d = waw_err_q
                  | (bus.issue_en && busy_q[bus.issue_dest]
                     && !(pop && (head_dest == bus.issue_dest)))
                  | (bus.wb_en && busy_q[bus.wb_dest])
                  | (push && stale_entry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_dest_q <= '{default: '0};
            fifo_data_q <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            age_q       <= '0;
            stall_req_q <= 1'b0;
            waw_err_q   <= 1'b0;
        end else begin
            fifo_dest_q <= fifo_dest_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            age_q       <= age_d;
            stall_req_q <= stall_req_d;
            waw_err_q   <= waw_err_d;
        end
    end

    assign bus.ext_ready = ext_ready;
    assign bus.hazard    = (bus.src1_en && busy_q[bus.src1] && !fwd1)
                         | (bus.src2_en && busy_q[bus.src2] && !fwd2);
    assign bus.stall_req = stall_req_q;
    assign bus.busy      = busy_q;
    assign bus.waw_err   = waw_err_q;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios plus random traffic checked
// against a queue-based reference model of the write-port rules.
module tb_regfile_write_scheduler;
    localparam int ADDR_W       = 4;
    localparam int DATA_W       = 32;
    localparam int NREGS        = 16;
    localparam int QDEPTH       = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    entry_t            m_q[$];
    logic [NREGS-1:0]  m_busy;
    bit                m_waw, m_stall, m_last_push;
    int                m_age;
    logic              e_we, e_ready, e_hazard;
    logic [ADDR_W-1:0] e_dest;
    logic [DATA_W-1:0] e_data;

    regfile_write_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)) bus_if ();

    regfile_write_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS),
        .QDEPTH(QDEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_q.delete();
        m_busy      = '0;
        m_waw       = 1'b0;
        m_stall     = 1'b0;
        m_last_push = 1'b0;
        m_age       = 0;
    endtask

    // Expected combinational outputs for the current model state and inputs.
    task automatic model_eval();
        bit pop;
        pop      = !bus_if.wb_en && (m_q.size() != 0);
        e_ready  = (m_q.size() < QDEPTH);
        e_we     = 1'b0;
        e_dest   = '0;
        e_data   = '0;
        if (bus_if.wb_en) begin
            e_we = 1'b1; e_dest = bus_if.wb_dest; e_data = bus_if.wb_data;
        end else if (pop) begin
            e_we = 1'b1; e_dest = m_q[0].dest; e_data = m_q[0].data;
        end
        e_hazard = (bus_if.src1_en && m_busy[bus_if.src1] && !(pop && m_q[0].dest == bus_if.src1))
                || (bus_if.src2_en && m_busy[bus_if.src2] && !(pop && m_q[0].dest == bus_if.src2));
    endtask

    // State change of the model at a clock edge, from the inputs present before it.
    task automatic model_commit();
        bit pop, push, stale, was_empty;
        was_empty = (m_q.size() == 0);
        pop   = !bus_if.wb_en && !was_empty;
        push  = bus_if.ext_valid && (m_q.size() < QDEPTH);
        stale = 1'b0;
        foreach (m_q[j]) if (!m_busy[m_q[j].dest]) stale = 1'b1;
        if (bus_if.issue_en && m_busy[bus_if.issue_dest]
            && !(pop && m_q[0].dest == bus_if.issue_dest)) m_waw = 1'b1;
        if (bus_if.wb_en && m_busy[bus_if.wb_dest]) m_waw = 1'b1;
        if (push && stale) m_waw = 1'b1;
        if (pop) m_busy[m_q[0].dest] = 1'b0;
        if (bus_if.issue_en) m_busy[bus_if.issue_dest] = 1'b1;
        if (was_empty || pop) m_age = 0;
        else if (m_age < STARVE_LIMIT) m_age++;
        m_stall = (m_age >= STARVE_LIMIT);
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back('{dest: bus_if.ext_dest, data: bus_if.ext_data});
        m_last_push = push;
    endtask

    task automatic drive_idle();
        bus_if.wb_en = 1'b0;      bus_if.wb_dest = '0;    bus_if.wb_data = '0;
        bus_if.issue_en = 1'b0;   bus_if.issue_dest = '0;
        bus_if.ext_valid = 1'b0;  bus_if.ext_dest = '0;   bus_if.ext_data = '0;
        bus_if.src1 = '0;         bus_if.src2 = '0;
        bus_if.src1_en = 1'b0;    bus_if.src2_en = 1'b0;
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        #2;
        n_checks++; if (bus_if.ext_ready !== 1'b1) begin n_fail++;
            $display("[TB] FAIL reset_ext_ready: got %b expected 1", bus_if.ext_ready); end
        do_reset();
        bus_if.src1_en = 1'b1; bus_if.src2_en = 1'b1; bus_if.src2 = 4'd9;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_checks++; if (bus_if.rf_we !== 1'b0) begin n_fail++;
                $display("[TB] FAIL idle_rf_we: got %b expected 0", bus_if.rf_we); end
            n_checks++; if (bus_if.busy !== 16'h0) begin n_fail++;
                $display("[TB] FAIL idle_busy: got %h expected 0", bus_if.busy); end
            n_checks++; if ({bus_if.hazard, bus_if.waw_err, bus_if.stall_req, bus_if.ext_ready} !== 4'b0001) begin n_fail++;
                $display("[TB] FAIL idle_flags: got %b expected 0001", {bus_if.hazard, bus_if.waw_err, bus_if.stall_req, bus_if.ext_ready}); end
            advance();
        end
    endtask

    task automatic test_ext_write();
        do_reset();
        bus_if.src1_en = 1'b1; bus_if.src1 = 4'd3;
        bus_if.issue_en = 1'b1; bus_if.issue_dest = 4'd3;
        #2;
        n_checks++; if (bus_if.hazard !== 1'b0) begin n_fail++;
            $display("[TB] FAIL ext_hazard_pre_issue: got %b expected 0", bus_if.hazard); end
        advance();
        bus_if.issue_en = 1'b0;
        bus_if.ext_valid = 1'b1; bus_if.ext_dest = 4'd3; bus_if.ext_data = 32'hDEADBEEF;
        #2;
        n_checks++; if (bus_if.hazard !== 1'b1) begin n_fail++;
            $display("[TB] FAIL ext_hazard_pending: got %b expected 1", bus_if.hazard); end
        n_checks++; if (bus_if.busy !== 16'h0008) begin n_fail++;
            $display("[TB] FAIL ext_busy_set: got %h expected 0008", bus_if.busy); end
        advance();
        bus_if.ext_valid = 1'b0;
        #2;
        n_checks++; if ({bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin n_fail++;
            $display("[TB] FAIL ext_write: got we=%b dest=%0d data=%h expected 1/3/deadbeef", bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data); end
        n_checks++; if (bus_if.hazard !== 1'b0) begin n_fail++;
            $display("[TB] FAIL ext_hazard_fwd: got %b expected 0", bus_if.hazard); end
        advance();
        #2;
        n_checks++; if (bus_if.busy !== 16'h0 || bus_if.rf_we !== 1'b0) begin n_fail++;
            $display("[TB] FAIL ext_after_pop: got busy=%h we=%b expected 0/0", bus_if.busy, bus_if.rf_we); end
        n_checks++; if (bus_if.waw_err !== 1'b0) begin n_fail++;
            $display("[TB] FAIL ext_waw: got %b expected 0", bus_if.waw_err); end
        advance();
    endtask

    task automatic test_collision();
        do_reset();
        bus_if.issue_en = 1'b1; bus_if.issue_dest = 4'd5;
        advance();
        bus_if.issue_en = 1'b0;
        bus_if.ext_dest = 4'd5; bus_if.ext_data = 32'h55;
        bus_if.wb_en = 1'b1; bus_if.wb_dest = 4'd1; bus_if.wb_data = 32'h11;
        for (int k = 0; k < 6; k++) begin
            bus_if.ext_valid = (k == 0);
            #2;
            n_checks++; if ({bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data} !== {1'b1, 4'd1, 32'h11}) begin n_fail++;
                $display("[TB] FAIL coll_wb_prio k=%0d: got %b/%0d/%h expected 1/1/11", k, bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data); end
            n_checks++; if (bus_if.stall_req !== (k >= 5)) begin n_fail++;
                $display("[TB] FAIL coll_stall k=%0d: got %b expected %b", k, bus_if.stall_req, k >= 5); end
            advance();
        end
        bus_if.wb_en = 1'b0;
        #2;
        n_checks++; if ({bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data, bus_if.stall_req} !== {1'b1, 4'd5, 32'h55, 1'b1}) begin n_fail++;
            $display("[TB] FAIL coll_drain: got %b/%0d/%h stall=%b expected 1/5/55 stall=1", bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data, bus_if.stall_req); end
        advance();
        #2;
        n_checks++; if ({bus_if.stall_req, bus_if.rf_we, bus_if.busy} !== {2'b00, 16'h0}) begin n_fail++;
            $display("[TB] FAIL coll_after: got stall=%b we=%b busy=%h expected 0/0/0", bus_if.stall_req, bus_if.rf_we, bus_if.busy); end
        advance();
    endtask

    task automatic test_fill();
        logic [ADDR_W-1:0] dests [3];
        logic [DATA_W-1:0] datas [3];
        dests = '{4'd2, 4'd4, 4'd6};
        datas = '{32'hA2, 32'hA4, 32'hA6};
        do_reset();
        for (int r = 0; r < 3; r++) begin
            bus_if.issue_en = 1'b1; bus_if.issue_dest = dests[r];
            advance();
        end
        bus_if.issue_en = 1'b0;
        bus_if.wb_en = 1'b1; bus_if.wb_dest = 4'd1; bus_if.wb_data = 32'h11;
        for (int f = 0; f < 4; f++) begin
            bus_if.ext_valid = 1'b1;
            bus_if.ext_dest = dests[(f < 2) ? f : 2];
            bus_if.ext_data = datas[(f < 2) ? f : 2];
            #2;
            n_checks++; if (bus_if.ext_ready !== (f < 2)) begin n_fail++;
                $display("[TB] FAIL fill_ready f=%0d: got %b expected %b", f, bus_if.ext_ready, f < 2); end
            advance();
        end
        bus_if.wb_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (d == 2) bus_if.ext_valid = 1'b0;
            #2;
            n_checks++; if ({bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data} !== {1'b1, dests[d], datas[d]}) begin n_fail++;
                $display("[TB] FAIL fill_order d=%0d: got %b/%0d/%h expected 1/%0d/%h", d, bus_if.rf_we, bus_if.rf_dest, bus_if.rf_data, dests[d], datas[d]); end
            n_checks++; if (bus_if.ext_ready !== (d != 0)) begin n_fail++;
                $display("[TB] FAIL fill_drain_ready d=%0d: got %b expected %b", d, bus_if.ext_ready, d != 0); end
            advance();
        end
        #2;
        n_checks++; if ({bus_if.rf_we, bus_if.busy, bus_if.waw_err} !== {1'b0, 16'h0, 1'b0}) begin n_fail++;
            $display("[TB] FAIL fill_end: got we=%b busy=%h waw=%b expected 0/0/0", bus_if.rf_we, bus_if.busy, bus_if.waw_err); end
        advance();
    endtask

    task automatic test_waw();
        do_reset();
        bus_if.issue_en = 1'b1; bus_if.issue_dest = 4'd7;
        advance();
        bus_if.issue_en = 1'b0;
        bus_if.ext_valid = 1'b1; bus_if.ext_dest = 4'd7; bus_if.ext_data = 32'h77;
        advance();
        bus_if.ext_valid = 1'b0;
        bus_if.issue_en = 1'b1;
        #2;
        n_checks++; if ({bus_if.rf_we, bus_if.rf_dest} !== {1'b1, 4'd7}) begin n_fail++;
            $display("[TB] FAIL waw_pop_r7: got %b/%0d expected 1/7", bus_if.rf_we, bus_if.rf_dest); end
        advance();
        bus_if.issue_en = 1'b0;
        #2;
        n_checks++; if ({bus_if.busy, bus_if.waw_err} !== {16'h0080, 1'b0}) begin n_fail++;
            $display("[TB] FAIL waw_same_cycle: got busy=%h waw=%b expected 0080/0", bus_if.busy, bus_if.waw_err); end
        bus_if.issue_en = 1'b1;
        advance();
        bus_if.issue_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_checks++; if (bus_if.waw_err !== 1'b1) begin n_fail++;
                $display("[TB] FAIL waw_sticky c=%0d: got %b expected 1", c, bus_if.waw_err); end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus_if.issue_en = 1'b1; bus_if.issue_dest = 4'd5;
        advance();
        bus_if.issue_dest = 4'd7;
        advance();
        bus_if.issue_en = 1'b0;
        bus_if.wb_en = 1'b1; bus_if.wb_dest = 4'd1; bus_if.wb_data = 32'h11;
        bus_if.ext_valid = 1'b1; bus_if.ext_dest = 4'd5; bus_if.ext_data = 32'h55;
        advance();
        bus_if.ext_dest = 4'd7; bus_if.ext_data = 32'h77;
        advance();
        bus_if.ext_valid = 1'b0;
        #2;
        n_checks++; if ({bus_if.busy, bus_if.ext_ready} !== {16'h00A0, 1'b0}) begin n_fail++;
            $display("[TB] FAIL rstmid_pre: got busy=%h ready=%b expected 00a0/0", bus_if.busy, bus_if.ext_ready); end
        rst = 1'b1;
        bus_if.wb_en = 1'b0;
        bus_if.ext_valid = 1'b1; bus_if.ext_dest = 4'd9;
        bus_if.src1_en = 1'b1; bus_if.src1 = 4'd5;
        model_reset();
        #1;
        n_checks++; if ({bus_if.busy, bus_if.ext_ready, bus_if.rf_we, bus_if.hazard, bus_if.stall_req, bus_if.waw_err} !== {16'h0, 5'b10000}) begin n_fail++;
            $display("[TB] FAIL rstmid_async: got busy=%h ready=%b we=%b haz=%b stall=%b waw=%b", bus_if.busy, bus_if.ext_ready, bus_if.rf_we, bus_if.hazard, bus_if.stall_req, bus_if.waw_err); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.ext_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_checks++; if ({bus_if.rf_we, bus_if.busy} !== {1'b0, 16'h0}) begin n_fail++;
                $display("[TB] FAIL rstmid_after c=%0d: got we=%b busy=%h expected 0/0", c, bus_if.rf_we, bus_if.busy); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int i = 0; i < 75; i++) begin
                if (!(bus_if.ext_valid && !m_last_push)) begin
                    bus_if.ext_valid = ($urandom_range(0, 9) < 4);
                    bus_if.ext_dest  = ADDR_W'($urandom_range(0, 3));
                    bus_if.ext_data  = $urandom;
                end
                bus_if.wb_en      = m_stall ? 1'b0 : 1'($urandom_range(0, 1));
                bus_if.wb_dest    = ADDR_W'($urandom_range(0, 15));
                bus_if.wb_data    = $urandom;
                bus_if.issue_en   = ($urandom_range(0, 3) == 0);
                bus_if.issue_dest = ADDR_W'($urandom_range(0, 3));
                bus_if.src1       = ADDR_W'($urandom_range(0, 3));
                bus_if.src2       = ADDR_W'($urandom_range(0, 3));
                bus_if.src1_en    = 1'($urandom_range(0, 1));
                bus_if.src2_en    = 1'($urandom_range(0, 1));
                #2;
                model_eval();
                n_checks++; if (bus_if.rf_we !== e_we) begin n_fail++;
                    $display("[TB] FAIL rand_rf_we s%0d c%0d: got %b expected %b", seg, i, bus_if.rf_we, e_we); end
                n_checks++; if (bus_if.rf_dest !== e_dest) begin n_fail++;
                    $display("[TB] FAIL rand_rf_dest s%0d c%0d: got %0d expected %0d", seg, i, bus_if.rf_dest, e_dest); end
                n_checks++; if (bus_if.rf_data !== e_data) begin n_fail++;
                    $display("[TB] FAIL rand_rf_data s%0d c%0d: got %h expected %h", seg, i, bus_if.rf_data, e_data); end
                n_checks++; if (bus_if.ext_ready !== e_ready) begin n_fail++;
                    $display("[TB] FAIL rand_ext_ready s%0d c%0d: got %b expected %b", seg, i, bus_if.ext_ready, e_ready); end
                n_checks++; if (bus_if.hazard !== e_hazard) begin n_fail++;
                    $display("[TB] FAIL rand_hazard s%0d c%0d: got %b expected %b", seg, i, bus_if.hazard, e_hazard); end
                n_checks++; if (bus_if.busy !== m_busy) begin n_fail++;
                    $display("[TB] FAIL rand_busy s%0d c%0d: got %h expected %h", seg, i, bus_if.busy, m_busy); end
                n_checks++; if (bus_if.waw_err !== m_waw) begin n_fail++;
                    $display("[TB] FAIL rand_waw s%0d c%0d: got %b expected %b", seg, i, bus_if.waw_err, m_waw); end
                n_checks++; if (bus_if.stall_req !== m_stall) begin n_fail++;
                    $display("[TB] FAIL rand_stall s%0d c%0d: got %b expected %b", seg, i, bus_if.stall_req, m_stall); end
                advance();
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_write();
        test_collision();
        test_fill();
        test_waw();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
